// File: rtl/leaf_loader_pkg.sv
// Shared definitions for the sorter blocks: loader FSM encoding and the default
// end-of-run terminator record.
package leaf_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TERM  = 2'd2
  } loader_state_t;

  localparam int TERM_DEFAULT = 0;

endpackage

// File: rtl/leaf_onehot.sv
// Leaf pointer to one-hot enqueue strobe decode, gated by the write enable.
module leaf_onehot #(
  parameter int N_LEAF = 64,
  parameter int PTR_W  = 6
) (
  input  logic              en,
  input  logic [PTR_W-1:0]  ptr,
  output logic [N_LEAF-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[ptr] = 1'b1;
  end

endmodule

// File: rtl/leaf_loader.sv
// Unpacks P-record input words into leaf FIFOs one record per cycle, appending
// a terminator after each run and moving to the next leaf once a run is closed.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | ready for a new word; no leaf writes
//   ST_SHIFT | writing latched records LSB-first to leaf[ptr]
//   ST_TERM  | writing the terminator, then advance ptr and count the run
module leaf_loader
  import leaf_loader_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    P          = 16,
  parameter int                    N_LEAF     = 64,
  parameter logic [DATA_WIDTH-1:0] TERM       = DATA_WIDTH'(TERM_DEFAULT)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P*DATA_WIDTH-1:0] i_data,
  input  logic                    i_valid,
  input  logic                    i_last,
  output logic                    o_ready,
  output logic [DATA_WIDTH-1:0]   o_leaf_data,
  output logic [N_LEAF-1:0]       o_leaf_write,
  input  logic [N_LEAF-1:0]       i_leaf_full,
  output logic [15:0]             o_run_count
);

  localparam int IDX_W = (P > 1) ? $clog2(P) : 1;
  localparam int PTR_W = (N_LEAF > 1) ? $clog2(N_LEAF) : 1;

  loader_state_t           state;
  logic [P*DATA_WIDTH-1:0] sreg;
  logic                    last_q;
  logic [IDX_W-1:0]        idx;
  logic [PTR_W-1:0]        ptr;
  logic [15:0]             run_count;
  logic                    write_en;

  // Only the currently selected leaf can stall us; other full flags are ignored.
  assign write_en    = (state != ST_IDLE) && !i_leaf_full[ptr];
  assign o_ready     = (state == ST_IDLE);
  assign o_run_count = run_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      sreg      <= '0;
      last_q    <= 1'b0;
      idx       <= '0;
      ptr       <= '0;
      run_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            sreg   <= i_data;
            last_q <= i_last;
            idx    <= '0;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The current record always sits in the low slice of sreg.
          if (write_en) begin
            sreg <= sreg >> DATA_WIDTH;
            if (idx == IDX_W'(P - 1)) begin
              idx   <= '0;
              state <= last_q ? ST_TERM : ST_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_TERM: begin
          if (write_en) begin
            ptr       <= (ptr == PTR_W'(N_LEAF - 1)) ? '0 : ptr + 1'b1;
            run_count <= run_count + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_leaf_data = '0;
    case (state)
      ST_SHIFT: o_leaf_data = sreg[DATA_WIDTH-1:0];
      ST_TERM:  o_leaf_data = TERM;
      default:  o_leaf_data = '0;
    endcase
  end

  leaf_onehot #(
    .N_LEAF (N_LEAF),
    .PTR_W  (PTR_W)
  ) u_onehot (
    .en     (write_en),
    .ptr    (ptr),
    .onehot (o_leaf_write)
  );

endmodule

// File: tb/tb_leaf_loader.sv
// Directed bench for leaf_loader with default parameters (32-bit records,
// 16 records per word, 64 leaves, terminator 0).
module tb_leaf_loader;

  localparam int DW = 32;
  localparam int P  = 16;
  localparam int NL = 64;

  logic            i_clk;
  logic            i_rst;
  logic [P*DW-1:0] i_data;
  logic            i_valid;
  logic            i_last;
  logic            o_ready;
  logic [DW-1:0]   o_leaf_data;
  logic [NL-1:0]   o_leaf_write;
  logic [NL-1:0]   i_leaf_full;
  logic [15:0]     o_run_count;

  int n_chk = 0;
  int n_err = 0;

  leaf_loader #(
    .DATA_WIDTH (DW),
    .P          (P),
    .N_LEAF     (NL)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .o_leaf_data  (o_leaf_data),
    .o_leaf_write (o_leaf_write),
    .i_leaf_full  (i_leaf_full),
    .o_run_count  (o_run_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [P*DW-1:0] mk_word(input int base, input int step);
    logic [P*DW-1:0] w;
    for (int k = 0; k < P; k++) w[k*DW +: DW] = DW'(base + k * step);
    return w;
  endfunction

  function automatic logic [P*DW-1:0] rand_word();
    logic [P*DW-1:0] w;
    for (int k = 0; k < P; k++) w[k*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  task automatic do_reset();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  // Entered at posedge+1 with the DUT expected in IDLE; returns at posedge+1 in IDLE.
  // stall_rec < 0 disables the stall; bg holds full flags of other leaves.
  task automatic do_word(input logic [P*DW-1:0] w, input bit last, input int leaf,
                         input int stall_rec, input int stall_len, input logic [NL-1:0] bg);
    logic [NL-1:0] oh;
    oh          = NL'(1) << leaf;
    i_leaf_full = bg;
    i_valid     = 1'b1;
    i_data      = w;
    i_last      = last;
    #1;
    chk("idle_ready", 64'(o_ready), 64'd1);
    chk("idle_write", 64'(o_leaf_write), 64'd0);
    chk("idle_data", 64'(o_leaf_data), 64'd0);
    @(posedge i_clk); #1;
    for (int k = 0; k < P; k++) begin
      if (k == stall_rec) begin
        for (int s = 0; s < stall_len; s++) begin
          i_leaf_full = bg | oh;
          i_valid     = 1'b1;
          i_data      = rand_word();
          #1;
          chk("stall_write", 64'(o_leaf_write), 64'd0);
          chk("stall_data", 64'(o_leaf_data), 64'(w[k*DW +: DW]));
          chk("stall_ready", 64'(o_ready), 64'd0);
          @(posedge i_clk); #1;
        end
      end
      i_leaf_full = bg;
      i_valid     = (k < P - 1);
      i_data      = rand_word();
      i_last      = 1'($urandom);
      #1;
      chk("shift_write", 64'(o_leaf_write), 64'(oh));
      chk("shift_data", 64'(o_leaf_data), 64'(w[k*DW +: DW]));
      chk("shift_ready", 64'(o_ready), 64'd0);
      @(posedge i_clk); #1;
    end
    if (last) begin
      i_valid = 1'b0;
      #1;
      chk("term_write", 64'(o_leaf_write), 64'(oh));
      chk("term_data", 64'(o_leaf_data), 64'd0);
      chk("term_ready", 64'(o_ready), 64'd0);
      @(posedge i_clk); #1;
    end
    i_valid     = 1'b0;
    i_leaf_full = '0;
  endtask

  initial begin
    logic [P*DW-1:0] w;
    i_rst       = 1'b1;
    i_data      = '0;
    i_valid     = 1'b0;
    i_last      = 1'b0;
    i_leaf_full = '0;
    do_reset();

    // Reset state and idle hold
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_write", 64'(o_leaf_write), 64'd0);
      chk("rst_data", 64'(o_leaf_data), 64'd0);
      chk("rst_count", 64'(o_run_count), 64'd0);
      @(posedge i_clk); #1;
    end

    // Single-word run 0x1..0x10 to leaf0, then next run must land on leaf1
    do_word(mk_word(1, 1), 1'b1, 0, -1, 0, '0);
    chk("run1_count", 64'(o_run_count), 64'd1);
    do_word(mk_word(32'h200, 3), 1'b1, 1, -1, 0, '0);
    chk("ptr1_count", 64'(o_run_count), 64'd2);

    // Three-word run to leaf0, 5-cycle stall after the 3rd record of word 1
    do_reset();
    do_word(mk_word(32'h1000, 1), 1'b0, 0, 3, 5, '0);
    do_word(mk_word(32'h2000, 1), 1'b0, 0, -1, 0, '0);
    do_word(mk_word(32'h3000, 1), 1'b1, 0, -1, 0, '0);
    chk("run3_count", 64'(o_run_count), 64'd1);

    // Full flags of other leaves never stall
    do_word(mk_word(32'h4000, 2), 1'b1, 1, -1, 0, 64'h20);
    do_word(mk_word(32'h5000, 2), 1'b1, 2, -1, 0, 64'h20);
    do_word(mk_word(32'h6000, 2), 1'b1, 3, -1, 0, ~64'h8);
    chk("other_full_count", 64'(o_run_count), 64'd4);

    // 65 single-word runs walk all leaves and wrap back to leaf0
    do_reset();
    for (int r = 0; r < 65; r++) do_word(rand_word(), 1'b1, r % NL, -1, 0, '0);
    chk("wrap_count", 64'(o_run_count), 64'd65);

    // Reset at index 7 discards the word and returns ptr and count to zero
    w = mk_word(32'h100, 1);
    i_valid = 1'b1;
    i_data  = w;
    i_last  = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("pre_rst_write", 64'(o_leaf_write), 64'd2);
      chk("pre_rst_data", 64'(o_leaf_data), 64'(w[k*DW +: DW]));
      @(posedge i_clk); #1;
    end
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("post_rst_write", 64'(o_leaf_write), 64'd0);
      chk("post_rst_data", 64'(o_leaf_data), 64'd0);
      chk("post_rst_ready", 64'(o_ready), 64'd1);
      chk("post_rst_count", 64'(o_run_count), 64'd0);
      @(posedge i_clk); #1;
    end
    do_word(mk_word(32'h700, 5), 1'b1, 0, -1, 0, '0);
    chk("post_rst_run", 64'(o_run_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
